decode_ctrl: RTL

Decode-stage controller for the RV32I pipeline. Accepts fetched instructions over a valid/ready handshake, holds them in a two-entry stage buffer, and derives from the head entry's opcode the `imm_op` select for the immediate generator plus the control bundle for EX. Presents the head to EX under a second valid/ready handshake, which decouples fetch from EX back-pressure, and supports a branch-redirect flush.

---
 rtl/decode_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_ctrl
// Purpose  : RV32I decode-stage controller. Two-entry stage buffer (head plus
//            skid) between fetch and EX valid/ready handshakes, with opcode
//            decode of the head entry into imm_op and the EX control bundle,
//            and a branch-redirect flush.
// Options  : DECODE_ILLEGAL_TRAP_EN - when defined, out_illegal flags a valid
//            head whose opcode is not a recognised RV32I major opcode.
// Revision : 1.0 - initial release
// ============================================================================
module decode_ctrl #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      imm_op,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic            alu_src,
  output logic            alu_a_pc,
  output logic [1:0]      wb_sel,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     head_instr_q, head_instr_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [PC_W-1:0] head_pc_q, head_pc_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;

  logic push;
  logic pop;

  // Ready depends on occupancy only, so fetch never sees EX back-pressure combinationally.
  assign in_ready  = (state_q != TWO) & rst_n;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid_q & out_ready;

  assign out_valid = out_valid_q;
  assign out_instr = head_instr_q;
  assign out_pc    = head_pc_q;

  // Buffer next-state: fill head first, overflow into skid, skid shifts to head on pop.
  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d      = ONE;
          head_instr_d = in_instr;
          head_pc_d    = in_pc;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_instr_d = in_instr;
          head_pc_d    = in_pc;
        end else if (push) begin
          state_d      = TWO;
          skid_instr_d = in_instr;
          skid_pc_d    = in_pc;
        end else if (pop) begin
          state_d      = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d      = ONE;
          head_instr_d = skid_instr_q;
          head_pc_d    = skid_pc_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A redirect discards everything; a pop in the same cycle has already completed.
    if (flush) begin
      state_d = EMPTY;
    end
    out_valid_d = (state_d != EMPTY);
  end

  // State and entry registers; reset clears both entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      out_valid_q  <= 1'b0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  // Head decode; everything stays 0 while the stage holds no valid entry.
  always_comb begin
    imm_op      = 3'b000;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_src     = 1'b0;
    alu_a_pc    = 1'b0;
    wb_sel      = 2'b00;
    out_illegal = 1'b0;
    if (out_valid_q) begin
      case (head_instr_q[6:0])
        7'b0110111: begin // LUI
          imm_op = 3'b100; reg_write = 1'b1; wb_sel = 2'b11;
        end
        7'b0010111: begin // AUIPC
          imm_op = 3'b100; reg_write = 1'b1; alu_src = 1'b1; alu_a_pc = 1'b1;
        end
        7'b1101111: begin // JAL
          imm_op = 3'b101; reg_write = 1'b1; jump = 1'b1; alu_src = 1'b1;
          alu_a_pc = 1'b1; wb_sel = 2'b10;
        end
        7'b1100111: begin // JALR
          imm_op = 3'b001; reg_write = 1'b1; jump = 1'b1; alu_src = 1'b1;
          wb_sel = 2'b10;
        end
        7'b1100011: begin // BRANCH
          imm_op = 3'b011; branch = 1'b1; alu_a_pc = 1'b1;
        end
        7'b0000011: begin // LOAD
          imm_op = 3'b001; reg_write = 1'b1; mem_read = 1'b1; alu_src = 1'b1;
          wb_sel = 2'b01;
        end
        7'b0100011: begin // STORE
          imm_op = 3'b010; mem_write = 1'b1; alu_src = 1'b1;
        end
        7'b0010011: begin // OP-IMM
          imm_op = 3'b001; reg_write = 1'b1; alu_src = 1'b1;
        end
        7'b0110011: begin // OP
          reg_write = 1'b1;
        end
        7'b0001111: begin // FENCE: no controls
        end
        7'b1110011: begin // SYSTEM: I-format immediate only
          imm_op = 3'b001;
        end
        default: begin
          // Unknown opcodes (including compressed encodings) decode as NOP.
`ifdef DECODE_ILLEGAL_TRAP_EN
          out_illegal = 1'b1;
`endif
        end
      endcase
    end
  end

endmodule
`default_nettype wire
